pattern_generator: RTL and testbench
====================================

Name: pattern_generator

Overview:
Serial pattern transmitter. It is the source end of the bit-stream interface consumed by the 8-bit pattern detector.
- On a start request it captures a WIDTH-bit word: the built-in PATTERN (11101100) or a user-supplied word.
- It shifts the word out MSB-first, one bit per clk, with a valid qualifier.
- It repeats the word a programmable number of times, with optional idle gap bits between words.
- It is used as the on-board stimulus source for detector bring-up and loopback tests.

Parameters:
WIDTH, 8, word length in bits (2..16)
PATTERN, 8'b11101100, built-in word sent when use_default=1
GAP_BITS, 2, idle cycles (dataout=0, dout_valid=0) between repeated words; 0 means back-to-back

Ports:
clk  input  1  rising-edge clock
rstn  input  1  reset, synchronous, active-low
start  input  1  start request; sampled only in IDLE
use_default  input  1  1: send PATTERN; 0: send pattern_in
pattern_in  input  WIDTH  user word; captured when start is accepted
repeat_cnt  input  4  number of words to send; 0 is treated as 1
abort  input  1  synchronous cancel of a transfer in progress
dataout  output  1  serial bit, MSB first (drives detector datain)
dout_valid  output  1  high when dataout carries a word or parity bit
busy  output  1  high from the first bit through the last bit
done  output  1  one-cycle pulse after the last bit of the last word
state  output  5  one-hot FSM state, for debug

Behaviour:
- Reset (rstn=0 at posedge): state=IDLE (5'd1); dataout=0, dout_valid=0, busy=0, done=0; shift register and counters cleared. Reset mid-transfer terminates immediately with no done pulse.
- All outputs are registered.
- States (one-hot):
  - IDLE=5'd1, SHIFT=5'd2, GAP=5'd4, PAR=5'd8, DONE=5'd16.
  - Unreachable encodings go to IDLE with outputs cleared.
- IDLE:
  - On start=1 and abort=0: capture word = use_default ? PATTERN : pattern_in.
  - Also capture words_left = (repeat_cnt==0) ? 1 : repeat_cnt.
  - At that edge: dataout<=word[WIDTH-1], dout_valid<=1, busy<=1, bit_cnt<=0; go to SHIFT.
  - Latency: the first bit appears in the cycle after start is sampled.
- SHIFT:
  - Each posedge presents the next bit, so WIDTH consecutive valid cycles per word.
  - pattern_in, use_default and repeat_cnt changes during a transfer are ignored.
- End of word:
  - words_left is decremented.
  - If words remain and GAP_BITS>0: GAP for exactly GAP_BITS cycles (dataout=0, dout_valid=0, busy=1), then SHIFT with the same captured word.
  - If words remain and GAP_BITS==0: the next word's MSB follows in the very next cycle.
  - If no words remain: go to DONE.
- DONE: a single cycle with done=1, busy=0, dout_valid=0, dataout=0; then IDLE. start is ignored in DONE.
- start while busy: ignored, no queuing.
- abort=1 while not in IDLE: at the next edge go to IDLE with dataout=0, dout_valid=0, busy=0 and no done pulse.
- abort in IDLE: no effect. abort and start high together in IDLE: start is ignored.

Optional Feature:
Macro PATGEN_PARITY_EN.
- When defined: after the last data bit of every word, enter PAR for one cycle.
  - dataout = even-parity bit (XOR of the captured word), dout_valid=1, busy=1.
  - Then GAP, SHIFT or DONE per the end-of-word rules.
  - Word length on the wire becomes WIDTH+1.
- When not defined: PAR is never entered and state[3] is constantly 0.

Test Plan:
1. Reset: rstn=0 for 2 cycles mid-transfer -> state=5'd1, dataout=0, dout_valid=0, busy=0, done=0, no done pulse.
2. Default single word: use_default=1, repeat_cnt=0, one-cycle start.
   - Cycles 1-8 after start: dataout=1,1,1,0,1,1,0,0 with dout_valid=1 and busy=1.
   - Cycle 9: done=1, busy=0. Cycle 10: state=IDLE.
3. User word, 3 repeats, GAP_BITS=2: pattern_in=8'hA5, use_default=0, repeat_cnt=3.
   - Three copies of 10100101, each separated by 2 cycles of dout_valid=0.
   - done=1 in cycle 29 after start.
   - pattern_in changed mid-transfer has no effect.
4. Abort: assert abort during bit 4 of word 1 -> next cycle dout_valid=0, busy=0, state=IDLE, done never asserts. A following start sends the full word normally. A start pulse while busy is ignored.
5. Loopback (macro undefined): GAP_BITS=0, repeat_cnt=2, default pattern, dataout wired to pattern detector datain with a shared clk/rstn -> detector hit pulses exactly twice, 8 cycles apart.
6. Parity (PATGEN_PARITY_EN defined):
   - Default pattern -> 9th valid bit = 1.
   - pattern_in=8'hA5 -> 9th valid bit = 0.
   - Single word: done in cycle 10.

Source files
------------

// File: rtl/pattern_generator_if.sv
// Bit-stream source bundle: request/config inputs and serial outputs of pattern_generator.
`timescale 1ns/1ps
interface pattern_generator_if #(
    parameter int WIDTH = 8
);
    logic             i_start;
    logic             i_use_default;
    logic [WIDTH-1:0] i_pattern_in;
    logic [3:0]       i_repeat_cnt;
    logic             i_abort;
    logic             o_dataout;
    logic             o_dout_valid;
    logic             o_busy;
    logic             o_done;
    logic [4:0]       o_state;

    modport master (
        output i_start, i_use_default, i_pattern_in, i_repeat_cnt, i_abort,
        input  o_dataout, o_dout_valid, o_busy, o_done, o_state
    );

    modport slave (
        input  i_start, i_use_default, i_pattern_in, i_repeat_cnt, i_abort,
        output o_dataout, o_dout_valid, o_busy, o_done, o_state
    );
endinterface

// File: rtl/pattern_generator.sv
// Serial MSB-first word transmitter with repeat count and inter-word gaps.
// Define PATGEN_PARITY_EN to append an even-parity bit after every word.
`timescale 1ns/1ps
module pattern_generator #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] PATTERN  = 8'b11101100,
    parameter int               GAP_BITS = 2
) (
    input logic               clk,
    input logic               rstn,
    pattern_generator_if.slave bus
);
    localparam int BW = $clog2(WIDTH);
    localparam int GW = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

    typedef enum logic [4:0] {
        IDLE  = 5'd1,
        SHIFT = 5'd2,
        GAP   = 5'd4,
        PAR   = 5'd8,
        DONE  = 5'd16
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] r_shift;
    logic [BW-1:0]    r_bit_cnt;
    logic [3:0]       r_words_left;
    logic [GW-1:0]    r_gap_cnt;
    logic             r_dataout;
    logic             r_valid;
    logic             r_busy;
    logic             r_done;

    logic [WIDTH-1:0] w_word;
    logic             w_last_bit;
    logic             w_more;
    state_t           w_eow_state;
    logic             w_eow_data;
    logic             w_eow_valid;
    logic             w_eow_busy;
    logic             w_eow_done;

    // words_left is decremented on the last data bit, so PAR sees the already-decremented count
    always_comb begin
        w_word     = bus.i_use_default ? PATTERN : bus.i_pattern_in;
        w_last_bit = (r_bit_cnt == BIT_LAST);
        w_more     = (r_state == PAR) ? (r_words_left != 4'd0) : (r_words_left != 4'd1);

        w_eow_state = DONE;
        w_eow_data  = 1'b0;
        w_eow_valid = 1'b0;
        w_eow_busy  = 1'b0;
        w_eow_done  = 1'b1;
        if (w_more) begin
            w_eow_done = 1'b0;
            w_eow_busy = 1'b1;
            if (GAP_BITS > 0) begin
                w_eow_state = GAP;
            end else begin
                w_eow_state = SHIFT;
                w_eow_data  = r_word[WIDTH-1];
                w_eow_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state      <= IDLE;
            r_word       <= '0;
            r_shift      <= '0;
            r_bit_cnt    <= '0;
            r_words_left <= '0;
            r_gap_cnt    <= '0;
            r_dataout    <= 1'b0;
            r_valid      <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
        end else if (r_state != IDLE && bus.i_abort) begin
            r_state   <= IDLE;
            r_dataout <= 1'b0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.i_start && !bus.i_abort) begin
                        r_word       <= w_word;
                        r_shift      <= {w_word[WIDTH-2:0], 1'b0};
                        r_words_left <= (bus.i_repeat_cnt == 4'd0) ? 4'd1 : bus.i_repeat_cnt;
                        r_bit_cnt    <= '0;
                        r_dataout    <= w_word[WIDTH-1];
                        r_valid      <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= SHIFT;
                    end else begin
                        r_dataout <= 1'b0;
                        r_valid   <= 1'b0;
                        r_busy    <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (!w_last_bit) begin
                        r_dataout <= r_shift[WIDTH-1];
                        r_shift   <= {r_shift[WIDTH-2:0], 1'b0};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end else begin
                        r_words_left <= r_words_left - 4'd1;
`ifdef PATGEN_PARITY_EN
                        r_state   <= PAR;
                        r_dataout <= ^r_word;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b1;
`else
                        r_state   <= w_eow_state;
                        r_dataout <= w_eow_data;
                        r_valid   <= w_eow_valid;
                        r_busy    <= w_eow_busy;
                        r_done    <= w_eow_done;
                        r_shift   <= {r_word[WIDTH-2:0], 1'b0};
                        r_bit_cnt <= '0;
                        r_gap_cnt <= '0;
`endif
                    end
                end
`ifdef PATGEN_PARITY_EN
                PAR: begin
                    r_state   <= w_eow_state;
                    r_dataout <= w_eow_data;
                    r_valid   <= w_eow_valid;
                    r_busy    <= w_eow_busy;
                    r_done    <= w_eow_done;
                    r_shift   <= {r_word[WIDTH-2:0], 1'b0};
                    r_bit_cnt <= '0;
                    r_gap_cnt <= '0;
                end
`endif
                GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state   <= SHIFT;
                        r_dataout <= r_word[WIDTH-1];
                        r_valid   <= 1'b1;
                        r_shift   <= {r_word[WIDTH-2:0], 1'b0};
                        r_bit_cnt <= '0;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                DONE: begin
                    r_state   <= IDLE;
                    r_dataout <= 1'b0;
                    r_valid   <= 1'b0;
                    r_busy    <= 1'b0;
                end
                default: begin
                    r_state   <= IDLE;
                    r_dataout <= 1'b0;
                    r_valid   <= 1'b0;
                    r_busy    <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_dataout    = r_dataout;
    assign bus.o_dout_valid = r_valid;
    assign bus.o_busy       = r_busy;
    assign bus.o_done       = r_done;
    assign bus.o_state      = r_state;
endmodule

// File: tb/tb_pattern_generator.sv
// Directed bench for pattern_generator: scoreboarded serial bits, timing, abort/reset and loopback.
`timescale 1ns/1ps
module tb_pattern_generator;
    localparam int WIDTH = 8;
    localparam logic [7:0] DEF = 8'b11101100;
`ifdef PATGEN_PARITY_EN
    localparam int WBITS = WIDTH + 1;
`else
    localparam int WBITS = WIDTH;
`endif

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    int checks = 0;
    int errors = 0;
    logic exp_q[$];
    int done_cnt = 0;
    int cyc      = 0;
    int hit_cnt  = 0;
    int hit_cyc[$];
    logic [7:0] det_sh = '0;

    pattern_generator_if #(.WIDTH(WIDTH)) bus ();
    pattern_generator_if #(.WIDTH(WIDTH)) bus0 ();

    pattern_generator #(.WIDTH(WIDTH), .PATTERN(DEF), .GAP_BITS(2)) u_dut (
        .clk(clk), .rstn(rstn), .bus(bus.slave)
    );
    pattern_generator #(.WIDTH(WIDTH), .PATTERN(DEF), .GAP_BITS(0)) u_loop (
        .clk(clk), .rstn(rstn), .bus(bus0.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void push_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) exp_q.push_back(w[i]);
`ifdef PATGEN_PARITY_EN
        exp_q.push_back(^w);
`endif
    endfunction

    // Scoreboard: every valid bit from the main instance must match the next queued bit
    always @(negedge clk) begin
        if (bus.o_dout_valid === 1'b1) begin
            chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) chk("serial_bit", 32'(bus.o_dataout), 32'(exp_q.pop_front()));
        end
        if (bus.o_done === 1'b1) done_cnt++;
        if (det_sh == DEF) begin
            hit_cnt++;
            hit_cyc.push_back(cyc);
        end
    end

    // Minimal 8-bit detector model fed from the loopback instance
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!rstn) det_sh <= '0;
        else       det_sh <= {det_sh[6:0], bus0.o_dataout};
    end

    task automatic pulse_start();
        @(posedge clk); #1 bus.i_start = 1'b1;
        @(posedge clk); #1 bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int exp, output int gaps, output int busy_n);
        int n;
        bit found;
        n = 0; found = 0; gaps = 0; busy_n = 0;
        while (!found && n < 200) begin
            @(negedge clk);
            n++;
            if (bus.o_done === 1'b1) found = 1;
            else begin
                if (bus.o_busy === 1'b1) busy_n++;
                if (bus.o_busy === 1'b1 && bus.o_dout_valid === 1'b0 && bus.o_dataout === 1'b0) gaps++;
            end
        end
        chk(tag, 32'(n), 32'(exp));
    endtask

    initial begin
        int gaps, busy_n, d0, n, vn, spacing;
        bus.i_start = 0; bus.i_use_default = 1; bus.i_pattern_in = '0; bus.i_repeat_cnt = '0; bus.i_abort = 0;
        bus0.i_start = 0; bus0.i_use_default = 1; bus0.i_pattern_in = '0; bus0.i_repeat_cnt = '0; bus0.i_abort = 0;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", 32'(bus.o_state), 32'd1);
        chk("rst_dataout", 32'(bus.o_dataout), 32'd0);
        chk("rst_valid", 32'(bus.o_dout_valid), 32'd0);
        chk("rst_busy", 32'(bus.o_busy), 32'd0);
        chk("rst_done", 32'(bus.o_done), 32'd0);
        rstn = 1'b1;

        // default word, repeat_cnt 0 treated as one word
        bus.i_use_default = 1; bus.i_repeat_cnt = 4'd0;
        push_word(DEF);
        pulse_start();
        wait_done("t2_done_cycle", WBITS + 1, gaps, busy_n);
        chk("t2_busy_cycles", 32'(busy_n), 32'(WBITS));
        chk("t2_busy_at_done", 32'(bus.o_busy), 32'd0);
        chk("t2_valid_at_done", 32'(bus.o_dout_valid), 32'd0);
        @(negedge clk);
        chk("t2_idle_after", 32'(bus.o_state), 32'd1);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);

        // user word, three repeats, inputs changed mid-transfer
        bus.i_use_default = 0; bus.i_pattern_in = 8'hA5; bus.i_repeat_cnt = 4'd3;
        push_word(8'hA5); push_word(8'hA5); push_word(8'hA5);
        pulse_start();
        bus.i_pattern_in = 8'h5A; bus.i_use_default = 1; bus.i_repeat_cnt = 4'd1;
        wait_done("t3_done_cycle", 3 * WBITS + 4 + 1, gaps, busy_n);
        chk("t3_gap_cycles", 32'(gaps), 32'd4);
        chk("t3_busy_cycles", 32'(busy_n), 32'(3 * WBITS + 4));
        @(negedge clk);
        chk("t3_idle_after", 32'(bus.o_state), 32'd1);
        chk("t3_queue_empty", 32'(exp_q.size()), 32'd0);

        // abort on bit 4, with an ignored start while busy
        bus.i_use_default = 1; bus.i_repeat_cnt = 4'd0;
        exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        d0 = done_cnt;
        pulse_start();
        @(posedge clk); #1 bus.i_start = 1; bus.i_use_default = 0; bus.i_pattern_in = 8'h00;
        @(posedge clk); #1 bus.i_start = 0;
        @(posedge clk); #1 bus.i_abort = 1;
        @(posedge clk); #1 bus.i_abort = 0;
        @(negedge clk);
        chk("t4_abort_valid", 32'(bus.o_dout_valid), 32'd0);
        chk("t4_abort_busy", 32'(bus.o_busy), 32'd0);
        chk("t4_abort_state", 32'(bus.o_state), 32'd1);
        repeat (5) @(negedge clk);
        chk("t4_no_done", 32'(done_cnt), 32'(d0));
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // abort and start together in IDLE: start ignored
        @(posedge clk); #1 bus.i_abort = 1; bus.i_start = 1;
        @(posedge clk); #1 bus.i_abort = 0; bus.i_start = 0;
        @(negedge clk);
        chk("t4_abort_start_idle", 32'(bus.o_state), 32'd1);

        bus.i_use_default = 1; bus.i_repeat_cnt = 4'd0;
        push_word(DEF);
        pulse_start();
        wait_done("t4_restart_done", WBITS + 1, gaps, busy_n);
        @(negedge clk);
        chk("t4_restart_queue", 32'(exp_q.size()), 32'd0);

        // reset mid-transfer after five bits
        bus.i_use_default = 0; bus.i_pattern_in = 8'hA5; bus.i_repeat_cnt = 4'd3;
        exp_q.push_back(1'b1); exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        d0 = done_cnt;
        pulse_start();
        repeat (4) @(posedge clk);
        #1 rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("t1_state", 32'(bus.o_state), 32'd1);
        chk("t1_dataout", 32'(bus.o_dataout), 32'd0);
        chk("t1_valid", 32'(bus.o_dout_valid), 32'd0);
        chk("t1_busy", 32'(bus.o_busy), 32'd0);
        chk("t1_done", 32'(bus.o_done), 32'd0);
        rstn = 1'b1;
        repeat (4) @(negedge clk);
        chk("t1_no_done", 32'(done_cnt), 32'(d0));
        chk("t1_queue_empty", 32'(exp_q.size()), 32'd0);

        // loopback: back-to-back words into the detector model
        bus0.i_use_default = 1; bus0.i_repeat_cnt = 4'd2;
        @(posedge clk); #1 bus0.i_start = 1;
        @(posedge clk); #1 bus0.i_start = 0;
        n = 0; vn = 0;
        while (n < 200 && bus0.o_done !== 1'b1) begin
            @(negedge clk);
            n++;
            if (bus0.o_dout_valid === 1'b1) vn++;
        end
        chk("t5_done_cycle", 32'(n), 32'(2 * WBITS + 1));
        chk("t5_valid_cycles", 32'(vn), 32'(2 * WBITS));
        repeat (10) @(negedge clk);
        chk("t5_hit_count", 32'(hit_cnt), 32'd2);
        spacing = (hit_cyc.size() >= 2) ? hit_cyc[1] - hit_cyc[0] : -1;
        chk("t5_hit_spacing", 32'(spacing), 32'(WBITS));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
